// File: rtl/grill_timer_bank.sv
// Bank of independent whole-second countdown timers, one-shot or periodic,
// each with its own prescaler so a started timer is accurate to one clock.
module grill_timer_bank #(
    parameter int NUM_CH        = 4,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int SEC_W         = 4,
    parameter int PRE_W         = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*SEC_W-1:0] duration,
    output logic [NUM_CH-1:0]       expire,
    output logic                    any_expire,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH*SEC_W-1:0] remaining
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [PRE_W-1:0]  pre_q   [NUM_CH];
    logic [PRE_W-1:0]  pre_d   [NUM_CH];
    logic [SEC_W-1:0]  rem_q   [NUM_CH];
    logic [SEC_W-1:0]  rem_d   [NUM_CH];
    logic [SEC_W-1:0]  dur_q   [NUM_CH];
    logic [SEC_W-1:0]  dur_d   [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] expire_q, expire_d;
    logic              any_expire_q, any_expire_d;

    // Priority per channel: start over stop over expiry.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every combinational output gets a default first so no path infers a latch.
            state_d[i]  = state_q[i];
            pre_d[i]    = pre_q[i];
            rem_d[i]    = rem_q[i];
            dur_d[i]    = dur_q[i];
            mode_d[i]   = mode_q[i];
            expire_d[i] = 1'b0;

            if (start[i]) begin
                dur_d[i]  = duration[i*SEC_W +: SEC_W];
                mode_d[i] = periodic[i];
                pre_d[i]  = '0;
                if (duration[i*SEC_W +: SEC_W] == '0) begin
                    state_d[i]  = IDLE;
                    rem_d[i]    = '0;
                    expire_d[i] = 1'b1;
                end else begin
                    state_d[i] = RUN;
                    rem_d[i]   = duration[i*SEC_W +: SEC_W];
                end
            end else if (state_q[i] == RUN) begin
                if (stop[i]) begin
                    state_d[i] = IDLE;
                    rem_d[i]   = '0;
                    pre_d[i]   = '0;
                end else if (pre_q[i] == PRE_LAST) begin
                    pre_d[i] = '0;
                    if (rem_q[i] == SEC_ONE) begin
                        expire_d[i] = 1'b1;
                        if (mode_q[i]) begin
                            rem_d[i] = dur_q[i];
                        end else begin
                            state_d[i] = IDLE;
                            rem_d[i]   = '0;
                        end
                    end else begin
                        rem_d[i] = rem_q[i] - SEC_ONE;
                    end
                end else begin
                    pre_d[i] = pre_q[i] + PRE_W'(1);
                end
            end
        end
        any_expire_d = |expire_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                pre_q[i]   <= '0;
                rem_q[i]   <= '0;
                dur_q[i]   <= '0;
            end
            mode_q       <= '0;
            expire_q     <= '0;
            any_expire_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                pre_q[i]   <= pre_d[i];
                rem_q[i]   <= rem_d[i];
                dur_q[i]   <= dur_d[i];
            end
            mode_q       <= mode_d;
            expire_q     <= expire_d;
            any_expire_q <= any_expire_d;
        end
    end

    always_comb begin
        remaining = '0;
        active    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            remaining[i*SEC_W +: SEC_W] = rem_q[i];
            active[i]                   = (state_q[i] == RUN);
        end
    end

    assign expire     = expire_q;
    assign any_expire = any_expire_q;

endmodule

// File: tb/tb_grill_timer_bank.sv
// Scoreboard bench for grill_timer_bank: expected expiry pulses are queued when
// a start is driven and matched by a negedge monitor when the DUT pulses.
module tb_grill_timer_bank;

    localparam int NUM_CH = 4;
    localparam int TPS    = 4;
    localparam int SEC_W  = 4;
    localparam int PRE_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       stop = '0;
    logic [NUM_CH-1:0]       periodic = '0;
    logic [NUM_CH*SEC_W-1:0] duration = '0;
    logic [NUM_CH-1:0]       expire;
    logic                    any_expire;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH*SEC_W-1:0] remaining;

    typedef struct {
        int unsigned       at;
        logic [NUM_CH-1:0] mask;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned t0;

    grill_timer_bank #(
        .NUM_CH(NUM_CH), .TICKS_PER_SEC(TPS), .SEC_W(SEC_W), .PRE_W(PRE_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .periodic(periodic), .duration(duration), .expire(expire),
        .any_expire(any_expire), .active(active), .remaining(remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (expire !== '0 || any_expire !== 1'b0)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d expire=%b any_expire=%b", cyc, expire, any_expire);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.at || expire !== mon_e.mask || any_expire !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse cyc=%0d expire=%b any=%b, expected cyc=%0d expire=%b any=1",
                             cyc, expire, any_expire, mon_e.at, mon_e.mask);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (expire !== '0 || any_expire !== 1'b0 || active !== '0 || remaining !== '0) begin
            errors++;
            $display("FAIL reset_hold expire=%b any=%b active=%b rem=%h, expected all 0",
                     expire, any_expire, active, remaining);
        end
        reset = 1'b0;
        step();
        checks++;
        if (expire !== '0 || any_expire !== 1'b0 || active !== '0 || remaining !== '0) begin
            errors++;
            $display("FAIL reset_release expire=%b any=%b active=%b rem=%h, expected all 0",
                     expire, any_expire, active, remaining);
        end
    endtask

    task automatic test_one_shot();
        logic       exp_act;
        logic [3:0] exp_rem;
        t0 = cyc;
        duration = 16'h0003;
        periodic = 4'b0000;
        start    = 4'b0001;
        sb.push_back('{t0 + 13, 4'b0001});
        step();
        start = '0;
        for (int k = 0; k <= 12; k++) begin
            exp_act = (k <= 11);
            exp_rem = (k < 12) ? 4'(3 - k / TPS) : 4'd0;
            checks++;
            if (active[0] !== exp_act || remaining[3:0] !== exp_rem) begin
                errors++;
                $display("FAIL one_shot k=%0d active=%b rem=%0d, expected active=%b rem=%0d",
                         k, active[0], remaining[3:0], exp_act, exp_rem);
            end
            if (k == 2) duration = 16'h0009;
            if (k < 12) step();
        end
        repeat (2) step();
        checks++;
        if (sb.size() != 0 || active !== '0) begin
            errors++;
            $display("FAIL one_shot_end pending=%0d active=%b, expected 0 and 0", sb.size(), active);
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_rem;
        t0 = cyc;
        duration = 16'h0020;
        periodic = 4'b0010;
        start    = 4'b0010;
        sb.push_back('{t0 + 9, 4'b0010});
        sb.push_back('{t0 + 17, 4'b0010});
        sb.push_back('{t0 + 25, 4'b0010});
        step();
        start    = '0;
        duration = '0;
        periodic = '0;
        for (int k = 0; k <= 26; k++) begin
            exp_rem = ((k % 8) < 4) ? 4'd2 : 4'd1;
            checks++;
            if (active[1] !== 1'b1 || remaining[7:4] !== exp_rem) begin
                errors++;
                $display("FAIL periodic k=%0d active=%b rem=%0d, expected active=1 rem=%0d",
                         k, active[1], remaining[7:4], exp_rem);
            end
            if (k == 26) stop = 4'b0010;
            step();
        end
        stop = '0;
        checks++;
        if (active[1] !== 1'b0 || remaining[7:4] !== 4'd0) begin
            errors++;
            $display("FAIL periodic_stop active=%b rem=%0d, expected 0 and 0", active[1], remaining[7:4]);
        end
        repeat (12) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL periodic_drain pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_zero_duration();
        for (int m = 0; m < 2; m++) begin
            t0 = cyc;
            duration = '0;
            periodic = (m == 1) ? 4'b0100 : 4'b0000;
            start    = 4'b0100;
            sb.push_back('{t0 + 1, 4'b0100});
            step();
            start = '0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (active[2] !== 1'b0 || remaining[11:8] !== 4'd0) begin
                    errors++;
                    $display("FAIL zero_dur m=%0d k=%0d active=%b rem=%0d, expected 0 and 0",
                             m, k, active[2], remaining[11:8]);
                end
                step();
            end
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL zero_dur_drain m=%0d pending=%0d, expected 0", m, sb.size());
            end
        end
        periodic = '0;
    endtask

    task automatic test_collisions();
        // Stop on the expiry edge: no pulse.
        duration = 16'h0001;
        start    = 4'b0001;
        step();
        start = '0;
        repeat (3) step();
        stop = 4'b0001;
        step();
        stop = '0;
        checks++;
        if (active[0] !== 1'b0 || remaining[3:0] !== 4'd0) begin
            errors++;
            $display("FAIL stop_vs_expiry active=%b rem=%0d, expected 0 and 0", active[0], remaining[3:0]);
        end
        repeat (6) step();

        // Restart on the expiry edge: only the new countdown pulses.
        t0 = cyc;
        duration = 16'h0001;
        start    = 4'b0001;
        step();
        start = '0;
        repeat (3) step();
        duration = 16'h0002;
        start    = 4'b0001;
        sb.push_back('{t0 + 13, 4'b0001});
        step();
        start = '0;
        checks++;
        if (active[0] !== 1'b1 || remaining[3:0] !== 4'd2) begin
            errors++;
            $display("FAIL restart_vs_expiry active=%b rem=%0d, expected 1 and 2", active[0], remaining[3:0]);
        end
        repeat (9) step();
        checks++;
        if (sb.size() != 0 || active[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_drain pending=%0d active=%b, expected 0 and 0", sb.size(), active[0]);
        end

        // Start and stop together while running: restart.
        t0 = cyc;
        duration = 16'h0001;
        start    = 4'b0001;
        step();
        start = '0;
        step();
        start = 4'b0001;
        stop  = 4'b0001;
        sb.push_back('{t0 + 7, 4'b0001});
        step();
        start = '0;
        stop  = '0;
        checks++;
        if (active[0] !== 1'b1 || remaining[3:0] !== 4'd1) begin
            errors++;
            $display("FAIL start_stop active=%b rem=%0d, expected 1 and 1", active[0], remaining[3:0]);
        end
        repeat (5) step();
        checks++;
        if (sb.size() != 0 || active[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_drain pending=%0d active=%b, expected 0 and 0", sb.size(), active[0]);
        end
    endtask

    task automatic test_multi_channel();
        t0 = cyc;
        duration = 16'h1111;
        start    = 4'b1111;
        sb.push_back('{t0 + 5, 4'b1111});
        step();
        start = '0;
        checks++;
        if (active !== 4'b1111 || remaining !== 16'h1111) begin
            errors++;
            $display("FAIL multi_start active=%b rem=%h, expected 1111 and 1111", active, remaining);
        end
        repeat (5) step();
        checks++;
        if (sb.size() != 0 || active !== '0) begin
            errors++;
            $display("FAIL multi_drain pending=%0d active=%b, expected 0 and 0", sb.size(), active);
        end
    endtask

    task automatic test_reset_mid();
        // Mid-count reset.
        duration = 16'h3333;
        start    = 4'b1111;
        step();
        start = '0;
        repeat (5) step();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (expire !== '0 || any_expire !== 1'b0 || active !== '0 || remaining !== '0) begin
            errors++;
            $display("FAIL reset_mid expire=%b any=%b active=%b rem=%h, expected all 0",
                     expire, any_expire, active, remaining);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) step();
        checks++;
        if (active !== '0 || remaining !== '0) begin
            errors++;
            $display("FAIL reset_mid_after active=%b rem=%h, expected 0 and 0", active, remaining);
        end

        // Reset while a pulse is being driven clears it at once.
        duration = 16'h1111;
        start    = 4'b1111;
        step();
        start = '0;
        repeat (4) step();
        checks++;
        if (expire !== 4'b1111 || any_expire !== 1'b1) begin
            errors++;
            $display("FAIL pulse_before_reset expire=%b any=%b, expected 1111 and 1", expire, any_expire);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (expire !== '0 || any_expire !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_pulse expire=%b any=%b, expected 0 and 0", expire, any_expire);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) step();
        checks++;
        if (sb.size() != 0 || active !== '0) begin
            errors++;
            $display("FAIL reset_drain pending=%0d active=%b, expected 0 and 0", sb.size(), active);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_zero_duration();
        test_collisions();
        test_multi_channel();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
